// File: rtl/controller_fsm_pkg.sv
// Shared types and encodings for the multicycle controller: states, opcode/ext
// fields, ALU ops, branch conditions, PSR bit positions and writeback mux codes.
package controller_pkg;

  localparam int WIDTH   = 16;
  localparam int REGBITS = 4;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_SHIFT,
    S_LD_ADDR, S_LD_WB, S_ST_ADDR, S_ST_WR,
    S_JAL, S_JCOND, S_BCOND, S_HALT
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_CMP = 4'b0111;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [1:0] CR_ALU   = 2'b00;
  localparam logic [1:0] CR_SHIFT = 2'b01;
  localparam logic [1:0] CR_MEM   = 2'b10;
  localparam logic [1:0] CR_PC    = 2'b11;

  // Immediate opcodes map onto the same ALU ops their R-type twins use.
  function automatic logic [3:0] imm_alu(input logic [3:0] op);
    case (op)
      OP_ADDI: imm_alu = ALU_ADD;
      OP_SUBI: imm_alu = ALU_SUB;
      OP_CMPI: imm_alu = ALU_CMP;
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_XORI: imm_alu = ALU_XOR;
      OP_MOVI: imm_alu = ALU_MOV;
      OP_LUI:  imm_alu = ALU_LUI;
      default: imm_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/controller_fsm_if.sv
// Datapath control bundle: instruction word and flags in, enables/selects out.
// master = controller side, slave = datapath side.
interface controller_fsm_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic [WIDTH-1:0]   instr;
  logic [7:0]         PSROut;
  logic               PCEN, PSREN, nextInstruction, updateAddress;
  logic               StoreReg, WriteData, regWrite;
  logic               ZeroExtend, PCinstruction, SrcB, shiftType;
  logic               JmpEN, BranchEN, JALEN;
  logic [REGBITS-1:0] ALUcond;
  logic [7:0]         shiftAmt;
  logic [1:0]         chooseResult;

  modport master (
    input  instr, PSROut,
    output PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData,
           regWrite, ZeroExtend, PCinstruction, SrcB, shiftType, JmpEN,
           BranchEN, JALEN, ALUcond, shiftAmt, chooseResult
  );

  modport slave (
    output instr, PSROut,
    input  PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData,
           regWrite, ZeroExtend, PCinstruction, SrcB, shiftType, JmpEN,
           BranchEN, JALEN, ALUcond, shiftAmt, chooseResult
  );
endinterface

// File: rtl/controller_fsm_cond_eval.sv
// Branch/jump condition evaluator: 4-bit condition code against PSR flags.
module cond_eval
  import controller_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [7:0] psr_i,
  output logic       taken_o
);

  logic c, l, f, z, n;
  logic unused_psr;

  assign c = psr_i[PSR_C];
  assign l = psr_i[PSR_L];
  assign f = psr_i[PSR_F];
  assign z = psr_i[PSR_Z];
  assign n = psr_i[PSR_N];
  assign unused_psr = ^{psr_i[4:3], psr_i[1]};

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_EQ: taken_o = z;
      CC_NE: taken_o = ~z;
      CC_CS: taken_o = c;
      CC_CC: taken_o = ~c;
      CC_HI: taken_o = l;
      CC_LS: taken_o = ~l;
      CC_GT: taken_o = n;
      CC_LE: taken_o = ~n;
      CC_FS: taken_o = f;
      CC_FC: taken_o = ~f;
      CC_LO: taken_o = ~l & ~z;
      CC_HS: taken_o = l | z;
      CC_LT: taken_o = ~n & ~z;
      CC_GE: taken_o = n | z;
      CC_UC: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/controller_fsm.sv
// Multicycle Moore control FSM driving all datapath enables/selects.
// HALT_ON_ILLEGAL_EN: undefined encodings park in HALT instead of acting as a NOP.
module controller_fsm
  import controller_pkg::*;
#(
  parameter int WIDTH   = controller_pkg::WIDTH,
  parameter int REGBITS = controller_pkg::REGBITS
) (
  input  logic              clk,
  input  logic              reset,
  controller_fsm_if.master  dp
);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   instr_w;
  logic [3:0]         op, rdest, ext;
  logic [3:0]         alu;
  logic               taken;

  assign instr_w = dp.instr;
  assign op      = instr_w[15:12];
  assign rdest   = instr_w[11:8];
  assign ext     = instr_w[7:4];
  assign alu     = (op == OP_RTYPE) ? ext : imm_alu(op);

  cond_eval u_cond (
    .cond_i  (rdest),
    .psr_i   (dp.PSROut),
    .taken_o (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    dp.PCEN            = 1'b0;
    dp.PSREN           = 1'b0;
    dp.nextInstruction = 1'b0;
    dp.updateAddress   = 1'b0;
    dp.StoreReg        = 1'b0;
    dp.WriteData       = 1'b0;
    dp.regWrite        = 1'b0;
    dp.ZeroExtend      = 1'b0;
    dp.PCinstruction   = 1'b0;
    dp.SrcB            = 1'b0;
    dp.shiftType       = 1'b0;
    dp.JmpEN           = 1'b0;
    dp.BranchEN        = 1'b0;
    dp.JALEN           = 1'b0;
    dp.ALUcond         = '0;
    dp.shiftAmt        = 8'h00;
    dp.chooseResult    = CR_ALU;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        dp.PCinstruction   = 1'b1;
        dp.nextInstruction = 1'b1;
        dp.PCEN            = 1'b1;
        state_d            = S_DECODE;
      end

      S_DECODE: begin
        case (op)
          OP_RTYPE, OP_ADDI, OP_SUBI, OP_CMPI, OP_ANDI,
          OP_ORI, OP_XORI, OP_MOVI, OP_LUI: state_d = S_EXEC;
          OP_SHIFT: state_d = S_SHIFT;
          OP_BCOND: state_d = S_BCOND;
          OP_MEM: begin
            case (ext)
              EXT_LOAD:  state_d = S_LD_ADDR;
              EXT_STOR:  state_d = S_ST_ADDR;
              EXT_JAL:   state_d = S_JAL;
              EXT_JCOND: state_d = S_JCOND;
`ifdef HALT_ON_ILLEGAL_EN
              default:   state_d = S_HALT;
`else
              default:   state_d = S_FETCH;
`endif
            endcase
          end
`ifdef HALT_ON_ILLEGAL_EN
          default: state_d = S_HALT;
`else
          default: state_d = S_FETCH;
`endif
        endcase
      end

      // R-type and immediate forms share one ALU op, so flag/write rules key off it.
      S_EXEC: begin
        dp.ALUcond    = alu[REGBITS-1:0];
        dp.SrcB       = (op != OP_RTYPE);
        dp.ZeroExtend = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        dp.regWrite   = (alu != ALU_CMP);
        dp.PSREN      = (alu == ALU_ADD) || (alu == ALU_SUB) || (alu == ALU_CMP);
        state_d       = S_FETCH;
      end

      S_SHIFT: begin
        dp.shiftType    = ~ext[2];
        dp.shiftAmt     = instr_w[7:0];
        dp.chooseResult = CR_SHIFT;
        dp.regWrite     = 1'b1;
        state_d         = S_FETCH;
      end

      S_LD_ADDR: begin
        dp.updateAddress = 1'b1;
        state_d          = S_LD_WB;
      end

      S_LD_WB: begin
        dp.chooseResult = CR_MEM;
        dp.regWrite     = 1'b1;
        state_d         = S_FETCH;
      end

      S_ST_ADDR: begin
        dp.updateAddress = 1'b1;
        state_d          = S_ST_WR;
      end

      S_ST_WR: begin
        dp.StoreReg  = 1'b1;
        dp.WriteData = 1'b1;
        state_d      = S_FETCH;
      end

      S_BCOND: begin
        dp.BranchEN = taken;
        dp.PCEN     = taken;
        state_d     = S_FETCH;
      end

      S_JCOND: begin
        dp.JmpEN = taken;
        dp.PCEN  = taken;
        state_d  = S_FETCH;
      end

      S_JAL: begin
        dp.JALEN        = 1'b1;
        dp.chooseResult = CR_PC;
        dp.regWrite     = 1'b1;
        dp.PCEN         = 1'b1;
        state_d         = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm.sv
// Directed-vector bench for controller_fsm: whole control word compared each cycle.
module tb_controller_fsm;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  controller_fsm_if #(.WIDTH(16), .REGBITS(4)) bus ();

  controller_fsm #(.WIDTH(16), .REGBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (bus.master)
  );

  // Control word layout: 14 single-bit controls, ALUcond, shiftAmt, chooseResult.
  localparam logic [27:0] M_PCEN  = 28'd1 << 27;
  localparam logic [27:0] M_PSREN = 28'd1 << 26;
  localparam logic [27:0] M_NI    = 28'd1 << 25;
  localparam logic [27:0] M_UA    = 28'd1 << 24;
  localparam logic [27:0] M_SR    = 28'd1 << 23;
  localparam logic [27:0] M_WD    = 28'd1 << 22;
  localparam logic [27:0] M_RW    = 28'd1 << 21;
  localparam logic [27:0] M_ZE    = 28'd1 << 20;
  localparam logic [27:0] M_PCI   = 28'd1 << 19;
  localparam logic [27:0] M_SRCB  = 28'd1 << 18;
  localparam logic [27:0] M_ST    = 28'd1 << 17;
  localparam logic [27:0] M_JMP   = 28'd1 << 16;
  localparam logic [27:0] M_BR    = 28'd1 << 15;
  localparam logic [27:0] M_JAL   = 28'd1 << 14;
  localparam logic [27:0] E_FETCH = M_PCEN | M_NI | M_PCI;

  function automatic logic [27:0] f_alu(input logic [3:0] a);
    return {14'b0, a, 10'b0};
  endfunction

  function automatic logic [27:0] f_amt(input logic [7:0] s);
    return {18'b0, s, 2'b0};
  endfunction

  function automatic logic [27:0] f_cr(input logic [1:0] c);
    return {26'b0, c};
  endfunction

  function automatic logic [27:0] obs();
    return {bus.PCEN, bus.PSREN, bus.nextInstruction, bus.updateAddress,
            bus.StoreReg, bus.WriteData, bus.regWrite, bus.ZeroExtend,
            bus.PCinstruction, bus.SrcB, bus.shiftType, bus.JmpEN,
            bus.BranchEN, bus.JALEN, bus.ALUcond, bus.shiftAmt, bus.chooseResult};
  endfunction

  task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %07h expected %07h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in FETCH; walks n post-fetch states then expects FETCH again.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic [7:0] psr,
                           input int n, input logic [27:0] e1, input logic [27:0] e2,
                           input logic [27:0] e3);
    logic [27:0] e;
    bus.instr  = ins;
    bus.PSROut = psr;
    for (int k = 0; k < n; k++) begin
      step();
      e = (k == 0) ? e1 : (k == 1) ? e2 : e3;
      check_eq($sformatf("%s_c%0d", tag, k + 2), obs(), e);
    end
    step();
    check_eq($sformatf("%s_fetch", tag), obs(), E_FETCH);
  endtask

  initial begin
    reset      = 1'b1;
    bus.instr  = 16'h0000;
    bus.PSROut = 8'h00;
    @(negedge clk);
    check_eq("reset_idle", obs(), 28'h0);
    reset = 1'b0;
    step();
    check_eq("first_fetch", obs(), E_FETCH);

    run_instr("add",   16'h0502, 8'h00, 2, 28'h0, M_RW | M_PSREN | f_alu(4'b0000), 28'h0);
    run_instr("sub_r", 16'h0512, 8'h00, 2, 28'h0, M_RW | M_PSREN | f_alu(4'b0001), 28'h0);
    run_instr("cmp_r", 16'h0572, 8'h00, 2, 28'h0, M_PSREN | f_alu(4'b0111), 28'h0);
    run_instr("cmpi",  16'hB30A, 8'h00, 2, 28'h0, M_SRCB | M_PSREN | f_alu(4'b0111), 28'h0);
    run_instr("andi",  16'h1F0F, 8'h00, 2, 28'h0, M_SRCB | M_ZE | M_RW | f_alu(4'b0010), 28'h0);
    run_instr("movi",  16'hD255, 8'h00, 2, 28'h0, M_SRCB | M_RW | f_alu(4'b0101), 28'h0);
    run_instr("lui",   16'hF000, 8'h00, 2, 28'h0, M_SRCB | M_RW | f_alu(4'b0110), 28'h0);
    run_instr("shli",  16'h8301, 8'h00, 2, 28'h0, M_ST | M_RW | f_cr(2'b01) | f_amt(8'h01), 28'h0);
    run_instr("shlr",  16'h8341, 8'h00, 2, 28'h0, M_RW | f_cr(2'b01) | f_amt(8'h41), 28'h0);
    run_instr("load",  16'h4304, 8'h00, 3, 28'h0, M_UA, M_RW | f_cr(2'b10));
    run_instr("store", 16'h4345, 8'h00, 3, 28'h0, M_UA, M_SR | M_WD);
    run_instr("beq_t", 16'hC0FE, 8'h40, 2, 28'h0, M_BR | M_PCEN, 28'h0);
    run_instr("beq_n", 16'hC0FE, 8'h00, 2, 28'h0, 28'h0, 28'h0);
    run_instr("blo_t", 16'hCA03, 8'h00, 2, 28'h0, M_BR | M_PCEN, 28'h0);
    run_instr("blo_n", 16'hCA03, 8'h04, 2, 28'h0, 28'h0, 28'h0);
    run_instr("bge_t", 16'hCD03, 8'h40, 2, 28'h0, M_BR | M_PCEN, 28'h0);
    run_instr("bcs_n", 16'hC203, 8'hFE, 2, 28'h0, 28'h0, 28'h0);
    run_instr("juc",   16'h4EC7, 8'h00, 2, 28'h0, M_JMP | M_PCEN, 28'h0);
    run_instr("jnev",  16'h4FC7, 8'hFF, 2, 28'h0, 28'h0, 28'h0);
    run_instr("jfs_t", 16'h48C7, 8'h20, 2, 28'h0, M_JMP | M_PCEN, 28'h0);
    run_instr("jal",   16'h4E87, 8'h00, 2, 28'h0, M_JAL | M_RW | M_PCEN | f_cr(2'b11), 28'h0);

`ifdef HALT_ON_ILLEGAL_EN
    bus.instr = 16'h6000;
    step();
    check_eq("illegal_decode", obs(), 28'h0);
    step();
    check_eq("halt_c1", obs(), 28'h0);
    step();
    check_eq("halt_c2", obs(), 28'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_eq("halt_exit_fetch", obs(), E_FETCH);
`else
    run_instr("nop",   16'h6000, 8'h00, 1, 28'h0, 28'h0, 28'h0);
    run_instr("nop_m", 16'h4310, 8'h00, 1, 28'h0, 28'h0, 28'h0);
`endif

    // Reset asserted during LD_WB must kill the writeback in the same cycle.
    bus.instr = 16'h4304;
    step();
    step();
    step();
    check_eq("ldwb_pre_reset", obs(), M_RW | f_cr(2'b10));
    reset = 1'b1;
    #1;
    check_eq("reset_mid_ldwb", obs(), 28'h0);
    step();
    check_eq("reset_held", obs(), 28'h0);
    reset = 1'b0;
    step();
    check_eq("fetch_after_reset", obs(), E_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
